// File: rtl/ahb_spm_mul.sv
// AHB-Lite slave around a bit-serial carry-save multiplier.
// One product bit retires per clock, LSB first; an operation takes 2*WIDTH cycles.
module ahb_spm_mul #(
  parameter int WIDTH = 32
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HSEL,
  input  logic        HREADY,
  input  logic        HWRITE,
  input  logic [1:0]  HTRANS,
  input  logic [2:0]  HSIZE,
  input  logic [31:0] HADDR,
  input  logic [31:0] HWDATA,
  output logic        HREADYOUT,
  output logic [1:0]  HRESP,
  output logic [31:0] HRDATA,
  output logic        IRQ
);

  localparam int PW    = 2 * WIDTH;
  localparam int CNT_W = $clog2(PW);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PW - 1);

  localparam logic [7:0] A_X      = 8'h00;
  localparam logic [7:0] A_Y      = 8'h04;
  localparam logic [7:0] A_PLO    = 8'h08;
  localparam logic [7:0] A_PHI    = 8'h0C;
  localparam logic [7:0] A_CTRL   = 8'h10;
  localparam logic [7:0] A_STATUS = 8'h14;

  typedef enum logic {IDLE, RUN} state_t;

  state_t            state_q, state_d;
  logic              acc_q, wr_q;
  logic [7:0]        addr_q;
  logic [WIDTH-1:0]  x_q, x_d, y_q, y_d;
  logic              sgn_q, sgn_d, ie_q, ie_d, done_q, done_d;
  logic [31:0]       plo_q, plo_d, phi_q, phi_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              wsgn_q, wsgn_d;
  logic [PW-1:0]     xe_q, xe_d, ye_q, ye_d;
  logic [PW-1:0]     s_q, s_d, c_q, c_d, prod_q, prod_d;

  logic [PW-1:0]        pp, fsum, fcar, prod_nxt;
  logic [PW-1:0]        x_sx, x_zx, y_sx, y_zx;
  logic signed [PW-1:0] fin_s;
  logic [63:0]          fin64;
  logic                 wr_en, wr_x, wr_y, wr_ctrl, wr_stat;
  logic                 start_wr, w1c, busy;
  logic                 unused_bits;

  assign HREADYOUT   = 1'b1;
  assign HRESP       = 2'b00;
  assign unused_bits = ^{HSIZE, HTRANS[0], HADDR[31:8], HWDATA};

  assign wr_en    = acc_q & wr_q;
  assign wr_x     = wr_en & (addr_q == A_X);
  assign wr_y     = wr_en & (addr_q == A_Y);
  assign wr_ctrl  = wr_en & (addr_q == A_CTRL);
  assign wr_stat  = wr_en & (addr_q == A_STATUS);
  assign start_wr = wr_ctrl & HWDATA[0];
  assign w1c      = wr_stat & HWDATA[1];
  assign busy     = (state_q == RUN);

  assign x_zx = PW'(x_q);
  assign y_zx = PW'(y_q);
  assign x_sx = {{WIDTH{x_q[WIDTH-1]}}, x_q};
  assign y_sx = {{WIDTH{y_q[WIDTH-1]}}, y_q};

  // Carry-save cell row: add the current Y bit times X into (s,c), retire bit 0, shift.
  always_comb begin
    pp       = xe_q & {PW{ye_q[0]}};
    fsum     = pp ^ s_q ^ c_q;
    fcar     = (pp & s_q) | (pp & c_q) | (s_q & c_q);
    prod_nxt = {fsum[0], prod_q[PW-1:1]};
  end

  assign fin_s = prod_nxt;
  assign fin64 = wsgn_q ? 64'(fin_s) : 64'(prod_nxt);

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    sgn_d   = sgn_q;
    ie_d    = ie_q;
    done_d  = done_q;
    plo_d   = plo_q;
    phi_d   = phi_q;
    cnt_d   = cnt_q;
    wsgn_d  = wsgn_q;
    xe_d    = xe_q;
    ye_d    = ye_q;
    s_d     = s_q;
    c_d     = c_q;
    prod_d  = prod_q;

    if (wr_x) x_d = HWDATA[WIDTH-1:0];
    if (wr_y) y_d = HWDATA[WIDTH-1:0];
    if (wr_ctrl) begin
      sgn_d = HWDATA[1];
      ie_d  = HWDATA[2];
    end
    if (start_wr || w1c) done_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (start_wr) begin
          state_d = RUN;
          cnt_d   = '0;
          wsgn_d  = HWDATA[1];
          xe_d    = HWDATA[1] ? x_sx : x_zx;
          ye_d    = HWDATA[1] ? y_sx : y_zx;
          s_d     = '0;
          c_d     = '0;
          prod_d  = '0;
        end
      end
      RUN: begin
        s_d    = {1'b0, fsum[PW-1:1]};
        c_d    = fcar;
        ye_d   = {1'b0, ye_q[PW-1:1]};
        prod_d = prod_nxt;
        cnt_d  = cnt_q + 1'b1;
        // Completion set is applied last so it wins over a same-cycle W1C.
        if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
          plo_d   = fin64[31:0];
          phi_d   = fin64[63:32];
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q <= IDLE;
      acc_q   <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      x_q     <= '0;
      y_q     <= '0;
      sgn_q   <= 1'b0;
      ie_q    <= 1'b0;
      done_q  <= 1'b0;
      plo_q   <= '0;
      phi_q   <= '0;
      cnt_q   <= '0;
      wsgn_q  <= 1'b0;
      xe_q    <= '0;
      ye_q    <= '0;
      s_q     <= '0;
      c_q     <= '0;
      prod_q  <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= HSEL & HREADY & HTRANS[1];
      wr_q    <= HWRITE;
      if (HSEL && HREADY && HTRANS[1]) addr_q <= HADDR[7:0];
      x_q     <= x_d;
      y_q     <= y_d;
      sgn_q   <= sgn_d;
      ie_q    <= ie_d;
      done_q  <= done_d;
      plo_q   <= plo_d;
      phi_q   <= phi_d;
      cnt_q   <= cnt_d;
      wsgn_q  <= wsgn_d;
      xe_q    <= xe_d;
      ye_q    <= ye_d;
      s_q     <= s_d;
      c_q     <= c_d;
      prod_q  <= prod_d;
    end
  end

  assign IRQ = done_q & ie_q;

  always_comb begin
    HRDATA = '0;
    case (addr_q)
      A_X:      HRDATA = 32'(x_q);
      A_Y:      HRDATA = 32'(y_q);
      A_PLO:    HRDATA = plo_q;
      A_PHI:    HRDATA = phi_q;
      A_CTRL:   HRDATA = {29'b0, ie_q, sgn_q, 1'b0};
      A_STATUS: HRDATA = {30'b0, done_q, busy};
      default:  HRDATA = '0;
    endcase
  end

endmodule

// File: tb/tb_ahb_spm_mul.sv
// Directed bench for ahb_spm_mul: a WIDTH=32 and a WIDTH=8 instance share the bus.
module tb_ahb_spm_mul;

  logic        HCLK = 1'b0;
  logic        HRESETn = 1'b0;
  logic [1:0]  hsel = 2'b00;
  logic        HREADY = 1'b1;
  logic        HWRITE = 1'b0;
  logic [1:0]  HTRANS = 2'b00;
  logic [2:0]  HSIZE = 3'b010;
  logic [31:0] HADDR = '0;
  logic [31:0] HWDATA = '0;

  logic        rdy32, rdy8, irq32, irq8;
  logic [1:0]  resp32, resp8;
  logic [31:0] rd32, rd8, rdata;

  int   cur = 0;
  int   vec = 0;
  int   err = 0;
  int   cyc = 0;
  logic ready_bad = 1'b0;

  assign rdata = (cur == 1) ? rd8 : rd32;

  ahb_spm_mul u32 (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(hsel[0]), .HREADY(HREADY), .HWRITE(HWRITE),
    .HTRANS(HTRANS), .HSIZE(HSIZE), .HADDR(HADDR), .HWDATA(HWDATA),
    .HREADYOUT(rdy32), .HRESP(resp32), .HRDATA(rd32), .IRQ(irq32)
  );

  ahb_spm_mul #(.WIDTH(8)) u8 (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(hsel[1]), .HREADY(HREADY), .HWRITE(HWRITE),
    .HTRANS(HTRANS), .HSIZE(HSIZE), .HADDR(HADDR), .HWDATA(HWDATA),
    .HREADYOUT(rdy8), .HRESP(resp8), .HRDATA(rd8), .IRQ(irq8)
  );

  always #5 HCLK = ~HCLK;
  always @(posedge HCLK) cyc <= cyc + 1;
  always @(negedge HCLK)
    if (rdy32 !== 1'b1 || rdy8 !== 1'b1 || resp32 !== 2'b00 || resp8 !== 2'b00) ready_bad <= 1'b1;

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic bus_idle();
    hsel   = 2'b00;
    HTRANS = 2'b00;
    HWRITE = 1'b0;
  endtask

  task automatic addr_phase(input logic [7:0] a, input logic w);
    hsel   = (cur == 1) ? 2'b10 : 2'b01;
    HTRANS = 2'b10;
    HWRITE = w;
    HADDR  = {24'h0, a};
  endtask

  task automatic ahb_write(input logic [7:0] a, input logic [31:0] d);
    addr_phase(a, 1'b1);
    tick();
    bus_idle();
    HWDATA = d;
    tick();
  endtask

  task automatic ahb_read(input logic [7:0] a, output logic [31:0] d);
    addr_phase(a, 1'b0);
    tick();
    bus_idle();
    d = rdata;
    tick();
  endtask

  // CTRL write whose data phase overlaps a STATUS read, then STATUS polled every cycle.
  task automatic start_measure(input logic [31:0] ctrl, output int n,
                               output logic [31:0] st, output logic irq);
    addr_phase(8'h10, 1'b1);
    tick();
    HWDATA = ctrl;
    addr_phase(8'h14, 1'b0);
    tick();
    n = 0;
    while (rdata[0] === 1'b1 && n < 300) begin
      n++;
      tick();
    end
    st  = rdata;
    irq = (cur == 1) ? irq8 : irq32;
    bus_idle();
    tick();
  endtask

  task automatic test_reset();
    logic [31:0] d;
    logic [7:0]  regs [6] = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14};
    HRESETn = 1'b0;
    repeat (3) tick();
    vec++;
    if (rd32 !== 32'h0 || rd8 !== 32'h0) begin
      err++; $display("FAIL rst_hrdata got %h/%h want 0", rd32, rd8);
    end
    vec++;
    if (irq32 !== 1'b0 || irq8 !== 1'b0) begin
      err++; $display("FAIL rst_irq got %b/%b want 0", irq32, irq8);
    end
    vec++;
    if (rdy32 !== 1'b1 || resp32 !== 2'b00) begin
      err++; $display("FAIL rst_ready got %b resp %b want 1/00", rdy32, resp32);
    end
    HRESETn = 1'b1;
    tick();
    for (int i = 0; i < 6; i++) begin
      ahb_read(regs[i], d);
      vec++;
      if (d !== 32'h0) begin
        err++; $display("FAIL rst_reg%0h got %h want 0", regs[i], d);
      end
    end
  endtask

  task automatic test_unmapped();
    logic [31:0] d;
    cur = 0;
    ahb_write(8'h00, 32'h12345678);
    ahb_write(8'h18, 32'hFFFFFFFF);
    ahb_write(8'h08, 32'hAAAA5555);
    ahb_read(8'h00, d);
    vec++;
    if (d !== 32'h12345678) begin err++; $display("FAIL x_rw got %h want 12345678", d); end
    ahb_read(8'h18, d);
    vec++;
    if (d !== 32'h0) begin err++; $display("FAIL unmapped_rd got %h want 0", d); end
    ahb_read(8'h08, d);
    vec++;
    if (d !== 32'h0) begin err++; $display("FAIL plo_ro got %h want 0", d); end
  endtask

  task automatic test_unsigned_max();
    logic [31:0] d, st;
    logic        irq;
    int          n;
    cur = 0;
    ahb_write(8'h00, 32'hFFFFFFFF);
    ahb_write(8'h04, 32'hFFFFFFFF);
    start_measure(32'h1, n, st, irq);
    vec++;
    if (n != 64) begin err++; $display("FAIL u32_busy got %0d want 64", n); end
    vec++;
    if (st !== 32'h2) begin err++; $display("FAIL u32_status got %h want 2", st); end
    ahb_read(8'h0C, d);
    vec++;
    if (d !== 32'hFFFFFFFE) begin err++; $display("FAIL u32_phi got %h want fffffffe", d); end
    ahb_read(8'h08, d);
    vec++;
    if (d !== 32'h00000001) begin err++; $display("FAIL u32_plo got %h want 1", d); end
    ahb_read(8'h10, d);
    vec++;
    if (d !== 32'h0) begin err++; $display("FAIL u32_ctrl got %h want 0", d); end
  endtask

  task automatic test_signed_irq();
    logic [31:0] d, st;
    logic        irq;
    int          n;
    cur = 0;
    ahb_write(8'h00, 32'hFFFFFFF1);
    ahb_write(8'h04, 32'h00000014);
    start_measure(32'h7, n, st, irq);
    vec++;
    if (n != 64 || st !== 32'h2) begin
      err++; $display("FAIL s32_busy got %0d/%h want 64/2", n, st);
    end
    vec++;
    if (irq !== 1'b1) begin err++; $display("FAIL s32_irq_rise got %b want 1", irq); end
    ahb_read(8'h0C, d);
    vec++;
    if (d !== 32'hFFFFFFFF) begin err++; $display("FAIL s32_phi got %h want ffffffff", d); end
    ahb_read(8'h08, d);
    vec++;
    if (d !== 32'hFFFFFED4) begin err++; $display("FAIL s32_plo got %h want fffffed4", d); end
    ahb_read(8'h10, d);
    vec++;
    if (d !== 32'h6) begin err++; $display("FAIL s32_ctrl got %h want 6", d); end
    ahb_write(8'h14, 32'h2);
    ahb_read(8'h14, d);
    vec++;
    if (d !== 32'h0) begin err++; $display("FAIL s32_w1c got %h want 0", d); end
    vec++;
    if (irq32 !== 1'b0) begin err++; $display("FAIL s32_irq_clr got %b want 0", irq32); end
  endtask

  task automatic test_width8();
    logic [31:0] d, st;
    logic        irq;
    int          n;
    cur = 1;
    ahb_write(8'h00, 32'h000000FF);
    ahb_write(8'h04, 32'h123456FF);
    ahb_read(8'h04, d);
    vec++;
    if (d !== 32'h000000FF) begin err++; $display("FAIL w8_y_zext got %h want ff", d); end
    start_measure(32'h1, n, st, irq);
    vec++;
    if (n != 16 || st !== 32'h2) begin
      err++; $display("FAIL w8u_busy got %0d/%h want 16/2", n, st);
    end
    ahb_read(8'h08, d);
    vec++;
    if (d !== 32'h0000FE01) begin err++; $display("FAIL w8u_plo got %h want fe01", d); end
    ahb_read(8'h0C, d);
    vec++;
    if (d !== 32'h0) begin err++; $display("FAIL w8u_phi got %h want 0", d); end
    start_measure(32'h3, n, st, irq);
    vec++;
    if (n != 16 || st !== 32'h2) begin
      err++; $display("FAIL w8s_busy got %0d/%h want 16/2", n, st);
    end
    ahb_read(8'h08, d);
    vec++;
    if (d !== 32'h00000001) begin err++; $display("FAIL w8s_plo got %h want 1", d); end
    ahb_read(8'h0C, d);
    vec++;
    if (d !== 32'h0) begin err++; $display("FAIL w8s_phi got %h want 0", d); end
    cur = 0;
  endtask

  task automatic test_start_during_run();
    logic [31:0] d;
    int          t0, t1, n;
    cur = 0;
    ahb_write(8'h00, 32'd3);
    ahb_write(8'h04, 32'd4);
    ahb_write(8'h10, 32'h1);
    t0 = cyc;
    repeat (8) tick();
    ahb_write(8'h00, 32'd7);
    ahb_write(8'h10, 32'h1);
    addr_phase(8'h14, 1'b0);
    tick();
    n = 0;
    while (rdata[0] === 1'b1 && n < 200) begin
      n++;
      tick();
    end
    t1 = cyc;
    bus_idle();
    tick();
    vec++;
    if (t1 - t0 != 64) begin err++; $display("FAIL sdr_schedule got %0d want 64", t1 - t0); end
    ahb_read(8'h08, d);
    vec++;
    if (d !== 32'd12) begin err++; $display("FAIL sdr_plo got %h want c", d); end
    ahb_read(8'h00, d);
    vec++;
    if (d !== 32'd7) begin err++; $display("FAIL sdr_x got %h want 7", d); end
    repeat (80) tick();
    ahb_read(8'h14, d);
    vec++;
    if (d !== 32'h2) begin err++; $display("FAIL sdr_no_rerun got %h want 2", d); end
  endtask

  task automatic test_reset_abort();
    logic [31:0] d, st;
    logic        irq;
    int          n;
    logic [7:0]  regs [6] = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14};
    cur = 0;
    ahb_write(8'h00, 32'd5);
    ahb_write(8'h04, 32'd6);
    ahb_write(8'h10, 32'h5);
    repeat (20) tick();
    HRESETn = 1'b0;
    #1;
    vec++;
    if (rd32 !== 32'h0 || irq32 !== 1'b0) begin
      err++; $display("FAIL abort_async got %h/%b want 0/0", rd32, irq32);
    end
    repeat (2) tick();
    HRESETn = 1'b1;
    tick();
    for (int i = 0; i < 6; i++) begin
      ahb_read(regs[i], d);
      vec++;
      if (d !== 32'h0) begin err++; $display("FAIL abort_reg%0h got %h want 0", regs[i], d); end
    end
    ahb_write(8'h00, 32'd5);
    ahb_write(8'h04, 32'd6);
    start_measure(32'h1, n, st, irq);
    vec++;
    if (n != 64 || st !== 32'h2) begin
      err++; $display("FAIL abort_rerun got %0d/%h want 64/2", n, st);
    end
    ahb_read(8'h08, d);
    vec++;
    if (d !== 32'd30) begin err++; $display("FAIL abort_plo got %h want 1e", d); end
  endtask

  task automatic test_w1c_collision();
    logic [31:0] d;
    cur = 0;
    ahb_write(8'h00, 32'd1);
    ahb_write(8'h04, 32'd1);
    ahb_write(8'h10, 32'h1);
    repeat (62) tick();
    addr_phase(8'h14, 1'b1);
    tick();
    bus_idle();
    HWDATA = 32'h2;
    tick();
    ahb_read(8'h14, d);
    vec++;
    if (d !== 32'h2) begin err++; $display("FAIL w1c_set_wins got %h want 2", d); end
    ahb_write(8'h14, 32'h2);
    ahb_read(8'h14, d);
    vec++;
    if (d !== 32'h0) begin err++; $display("FAIL w1c_later got %h want 0", d); end
  endtask

  task automatic test_ready();
    vec++;
    if (ready_bad !== 1'b0) begin
      err++; $display("FAIL hreadyout_hresp got bad=%b want 0", ready_bad);
    end
  endtask

  initial begin
    test_reset();
    test_unmapped();
    test_unsigned_max();
    test_signed_irq();
    test_width8();
    test_start_during_run();
    test_reset_abort();
    test_w1c_collision();
    test_ready();
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule
